// File: rtl/encoder_priority_n_seq.sv
// rtl/encoder_priority_n_seq.sv - registered N-to-log2(N) priority encoder, fixed or round-robin, valid/ready on both sides.
// Optional multi_hot output is enabled by defining ENCODER_MULTI_HOT_EN.
module encoder_priority_n_seq #(
    parameter int N           = 8,
    parameter int ROUND_ROBIN = 0,
    localparam int OUT_W      = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     d_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] d_out,
    output logic             invalid_input,
    output logic             out_valid,
`ifdef ENCODER_MULTI_HOT_EN
    output logic             multi_hot,
`endif
    input  logic             out_ready
);

    logic [OUT_W-1:0] r_d_out;
    logic             r_invalid;
    logic             r_valid;
    logic [OUT_W-1:0] r_ptr;

    logic             w_accept;
    logic             w_zero;
    logic [OUT_W-1:0] w_fix_idx;
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_hi;
    logic [OUT_W-1:0] w_hi_idx;
    logic [OUT_W-1:0] w_lo_idx;
    logic [OUT_W-1:0] w_rr_idx;
    logic [OUT_W-1:0] w_win;
    logic [OUT_W-1:0] w_ptr_nxt;

    assign in_ready = !rst && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_zero   = ~|d_in;

    always_comb begin
        w_fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (d_in[i]) w_fix_idx = OUT_W'(i);
        end
    end

    // Round-robin: prefer the lowest set bit at or above ptr, else wrap to the lowest set bit overall.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(r_ptr));
        end
    end

    assign w_hi = d_in & w_mask;

    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_hi[i]) w_hi_idx = OUT_W'(i);
            if (d_in[i]) w_lo_idx = OUT_W'(i);
        end
    end

    assign w_rr_idx  = (|w_hi) ? w_hi_idx : w_lo_idx;
    assign w_win     = (ROUND_ROBIN != 0) ? w_rr_idx : w_fix_idx;
    assign w_ptr_nxt = (w_rr_idx == OUT_W'(N - 1)) ? '0 : w_rr_idx + OUT_W'(1);

`ifdef ENCODER_MULTI_HOT_EN
    logic r_multi_hot;
    logic w_multi;

    assign w_multi   = |(d_in & (d_in - N'(1)));
    assign multi_hot = r_multi_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_multi_hot <= 1'b0;
        end else if (w_accept) begin
            r_multi_hot <= w_multi;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out   <= '0;
            r_invalid <= 1'b0;
            r_valid   <= 1'b0;
            r_ptr     <= '0;
        end else if (w_accept) begin
            r_d_out   <= w_win;
            r_invalid <= w_zero;
            r_valid   <= 1'b1;
            if ((ROUND_ROBIN != 0) && !w_zero) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign d_out         = r_d_out;
    assign invalid_input = r_invalid;
    assign out_valid     = r_valid;

endmodule

// File: tb/tb_encoder_priority_n_seq.sv
// tb/tb_encoder_priority_n_seq.sv - bench for encoder_priority_n_seq: N=4 fixed, N=4 round-robin and N=5 round-robin in lockstep.
// Multi-hot checks are compiled in when ENCODER_MULTI_HOT_EN is defined.
module tb_encoder_priority_n_seq;

    typedef struct packed {
        logic [1:0] f4;
        logic [1:0] r4;
        logic [2:0] r5;
        logic       i4;
        logic       i5;
        logic       m4;
        logic       m5;
    } exp_t;

    typedef struct packed {
        logic [4:0] d;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] d_in = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    exp_t       exp_cur = '0;

    logic       ir_f4, ir_r4, ir_r5;
    logic       ov_f4, ov_r4, ov_r5;
    logic       iv_f4, iv_r4, iv_r5;
    logic [1:0] do_f4, do_r4;
    logic [2:0] do_r5;
`ifdef ENCODER_MULTI_HOT_EN
    logic       mh_f4, mh_r4, mh_r5;
`endif

    int n_pass = 0;
    int n_total = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    encoder_priority_n_seq #(.N(4), .ROUND_ROBIN(0)) u_f4 (
        .clk(clk), .rst(rst), .d_in(d_in[3:0]), .in_valid(in_valid), .in_ready(ir_f4),
        .d_out(do_f4), .invalid_input(iv_f4), .out_valid(ov_f4),
`ifdef ENCODER_MULTI_HOT_EN
        .multi_hot(mh_f4),
`endif
        .out_ready(out_ready));

    encoder_priority_n_seq #(.N(4), .ROUND_ROBIN(1)) u_r4 (
        .clk(clk), .rst(rst), .d_in(d_in[3:0]), .in_valid(in_valid), .in_ready(ir_r4),
        .d_out(do_r4), .invalid_input(iv_r4), .out_valid(ov_r4),
`ifdef ENCODER_MULTI_HOT_EN
        .multi_hot(mh_r4),
`endif
        .out_ready(out_ready));

    encoder_priority_n_seq #(.N(5), .ROUND_ROBIN(1)) u_r5 (
        .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(ir_r5),
        .d_out(do_r5), .invalid_input(iv_r5), .out_valid(ov_r5),
`ifdef ENCODER_MULTI_HOT_EN
        .multi_hot(mh_r5),
`endif
        .out_ready(out_ready));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    // Scoreboard: compare the head while a result is shown, pop on drain, push on accept.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_f4_rst", {31'd0, ir_f4}, 32'd0);
            check("in_ready_r4_rst", {31'd0, ir_r4}, 32'd0);
            check("in_ready_r5_rst", {31'd0, ir_r5}, 32'd0);
            q.delete();
        end else begin
            check("out_valid_f4", {31'd0, ov_f4}, {31'd0, q.size() > 0});
            check("out_valid_r4", {31'd0, ov_r4}, {31'd0, q.size() > 0});
            check("out_valid_r5", {31'd0, ov_r5}, {31'd0, q.size() > 0});
            check("in_ready_f4", {31'd0, ir_f4}, {31'd0, (q.size() == 0) || out_ready});
            check("in_ready_r5", {31'd0, ir_r5}, {31'd0, (q.size() == 0) || out_ready});
            if (q.size() > 0) begin
                check("d_out_f4", {30'd0, do_f4}, {30'd0, q[0].f4});
                check("d_out_r4", {30'd0, do_r4}, {30'd0, q[0].r4});
                check("d_out_r5", {29'd0, do_r5}, {29'd0, q[0].r5});
                check("invalid_f4", {31'd0, iv_f4}, {31'd0, q[0].i4});
                check("invalid_r4", {31'd0, iv_r4}, {31'd0, q[0].i4});
                check("invalid_r5", {31'd0, iv_r5}, {31'd0, q[0].i5});
`ifdef ENCODER_MULTI_HOT_EN
                check("multi_hot_f4", {31'd0, mh_f4}, {31'd0, q[0].m4});
                check("multi_hot_r4", {31'd0, mh_r4}, {31'd0, q[0].m4});
                check("multi_hot_r5", {31'd0, mh_r5}, {31'd0, q[0].m5});
`endif
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && ir_f4) q.push_back(exp_cur);
        end
    end

    task automatic drive(input logic [4:0] d, input logic v, input logic rdy, input exp_t e);
        @(posedge clk);
        #1;
        d_in      = d;
        in_valid  = v;
        out_ready = rdy;
        exp_cur   = e;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ov"}, {29'd0, ov_f4, ov_r4, ov_r5}, 32'd0);
        check({tag, "_dout"}, {25'd0, do_f4, do_r4, do_r5}, 32'd0);
        check({tag, "_inv"}, {29'd0, iv_f4, iv_r4, iv_r5}, 32'd0);
`ifdef ENCODER_MULTI_HOT_EN
        check({tag, "_mh"}, {29'd0, mh_f4, mh_r4, mh_r5}, 32'd0);
`endif
    endtask

    vec_t tbl[16];

    initial begin
        // {d_in, {f4, r4, r5, inv4, inv5, mh4, mh5}}
        tbl[0]  = '{5'b01111, '{2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1}};
        tbl[1]  = '{5'b01111, '{2'd3, 2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1}};
        tbl[2]  = '{5'b00000, '{2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{5'b01111, '{2'd3, 2'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1}};
        tbl[4]  = '{5'b01111, '{2'd3, 2'd3, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1}};
        tbl[5]  = '{5'b01111, '{2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1}};
        tbl[6]  = '{5'b00110, '{2'd2, 2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1}};
        tbl[7]  = '{5'b10001, '{2'd0, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[8]  = '{5'b10001, '{2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[9]  = '{5'b10001, '{2'd0, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[10] = '{5'b10001, '{2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[11] = '{5'b10000, '{2'd0, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[12] = '{5'b01000, '{2'd3, 2'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[13] = '{5'b00101, '{2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1}};
        tbl[14] = '{5'b00100, '{2'd2, 2'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[15] = '{5'b00000, '{2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Streaming at full throughput; round-robin pointers end at 3 for both N=4 and N=5
        for (int i = 0; i < 16; i++) drive(tbl[i].d, 1'b1, 1'b1, tbl[i].e);
        drive(5'b00000, 1'b0, 1'b1, '0);

        // Backpressure: result 3 held for three stalled cycles, 0001 waits for the drain
        drive(5'b01000, 1'b1, 1'b0, '{2'd3, 2'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            drive(5'b00001, 1'b1, 1'b0, '{2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
            @(negedge clk);
            check("bp_in_ready", {31'd0, ir_r4}, 32'd0);
            check("bp_d_out_f4", {30'd0, do_f4}, 32'd3);
        end
        drive(5'b00001, 1'b1, 1'b1, '{2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        drive(5'b00000, 1'b0, 1'b1, '0);
        @(negedge clk);
        check("bp_new_d_out_f4", {30'd0, do_f4}, 32'd0);

        // Reset with a pending result after the pointers have reached 2
        drive(5'b01111, 1'b1, 1'b1, '{2'd3, 2'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1});
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        exp_cur   = '{2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        check_idle("mid_reset");
        drive(5'b00000, 1'b0, 1'b1, '0);
        drive(5'b00000, 1'b0, 1'b1, '0);
        @(negedge clk);
        check("drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/encoder_priority_n_seq.md
# encoder_priority_n_seq

Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshake on both sides and a selectable fixed-priority or round-robin mode. Successor to the 4-to-2 combinational encoders. Sits between request sources and downstream index consumers: accepts one request vector per handshake, returns the winning index one cycle later, and holds it until the consumer takes it.

## Interface
- `N`, default 8: input vector width; legal N >= 2, any integer.
- `ROUND_ROBIN`, default 0: 0 = fixed priority, highest set index wins; 1 = rotating priority.
- Local `OUT_W` = $clog2(N); not overridable.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_in`  in  N  request vector.
- `in_valid`  in  1  `d_in` presented.
- `in_ready`  out  1  block can accept `d_in` this cycle.
- `d_out`  out  OUT_W  registered winning index.
- `invalid_input`  out  1  registered; 1 when the accepted `d_in` was all zeros.
- `out_valid`  out  1  `d_out`/`invalid_input` hold a result.
- `out_ready`  in  1  consumer takes the result this cycle.

## Operation
- One-entry output register; no internal queue.
- `in_ready` = !rst && (!out_valid || out_ready); combinational.
- Accept: `in_valid && in_ready` at a rising edge. Load `d_out`, `invalid_input`, and set `out_valid`=1.
- Drain: `out_valid && out_ready` with no accept clears `out_valid`. Drain and accept in the same cycle: new result replaces old, `out_valid` stays 1.
- Fixed mode: `d_out` = highest index i with `d_in[i]`=1.
- Round-robin mode: internal pointer `ptr` (OUT_W bits, range 0..N-1). Search starts at `ptr` and runs upward, wrapping from N-1 to 0. The first set bit wins. On accept of a non-zero vector, `ptr` <= (winner+1) mod N; wrap must be correct for non-power-of-2 N.
- All-zero accept: `d_out`=0, `invalid_input`=1, `out_valid`=1, `ptr` unchanged.
- Non-zero accept: `invalid_input`=0.
- While `out_valid`=1 && `out_ready`=0: outputs held stable; `in_ready`=0; `d_in` is ignored.

## Timing
- Reset values: `d_out`=0, `invalid_input`=0, `out_valid`=0, `ptr`=0, `multi_hot`=0 (when present). `in_ready`=0 during any cycle with `rst`=1.
- Latency: accept at edge k gives `out_valid`=1 with the result after edge k.
- Throughput: one result per cycle while `out_ready`=1.
- Reset mid-operation: a pending result is discarded and `ptr` returns to 0. An `in_valid` during reset is not accepted.
- `out_ready` with `out_valid`=0: no effect.

## Configuration
- Macro `ENCODER_MULTI_HOT_EN`.
- Defined: adds output `multi_hot` (1 bit), registered with `d_out`. It is 1 when the accepted `d_in` had two or more bits set, else 0. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

## Test plan
- N=4, fixed mode, `out_ready`=1: accept `d_in`=0110 → next cycle `d_out`=2, `invalid_input`=0, `out_valid`=1. Accept 0000 → `d_out`=0, `invalid_input`=1.
- N=4, round-robin, `d_in`=1111 held with `in_valid`=1, `out_ready`=1 → `d_out` sequence 0,1,2,3,0. Insert 0000 mid-stream → `invalid_input`=1 and the sequence continues from the same `ptr`.
- N=5, round-robin, `d_in`=10001 repeated → `d_out` alternates 0,4,0,4. Checks non-power-of-2 wrap.
- Backpressure: `out_ready`=0 for 3 cycles after a result for `d_in`=1000 → `d_out`=3 stable, `in_ready`=0. New `d_in`=0001 is presented but not accepted until the drain cycle, then `d_out`=0.
- Reset mid-operation, round-robin N=4: after `ptr` has advanced to 2, assert `rst` for 1 cycle → `out_valid`=0, `d_out`=0, `in_ready`=0 during reset. Next `d_in`=1111 → `d_out`=0.
- With `ENCODER_MULTI_HOT_EN` defined: `d_in`=0100 → `multi_hot`=0; `d_in`=0101 → `multi_hot`=1; reset → `multi_hot`=0.
